// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Second stage of the MIPS pipeline (IF/ID boundary).
//
// Fetch's pc/ir pair is decoded and captured into one stage register, so every
// output changes on the edge that samples pc_i/ir_i (1-cycle latency). The
// 32x32 register file sits inside this stage. Its two read ports are indexed
// combinationally by ir_i[25:21] and ir_i[20:16], and their values are
// registered as rs_data_o/rt_data_o. Its single write port is driven by
// writeback and updates regardless of stall/flush. r0 always reads as zero.
//
// Optional build macro: DECODE_WB_BYPASS_EN
//   defined   : a same-cycle writeback to a register being read supplies
//               wb_data_i as the captured operand.
//   undefined : the captured operand is the pre-write register value.
//               Execute-side forwarding covers that case.
//
// Ports
//   clk_i, rst_ni        clock (rising edge) / asynchronous active-low reset
//   stall_i, flush_i     hold all outputs / kill the capture (flush wins)
//   pc_i, ir_i           fetch pc and instruction
//   wb_en_i/addr_i/data_i  register file write port
//   valid_o, pc_o        live-instruction flag and its pc
//   rs_o, rt_o, dest_o   register indices
//   rs_data_o, rt_data_o operand values
//   imm_o                extended immediate / shift amount / link value
//   alu_op_o, alu_src_o  ALU function, second-operand select (1 = imm_o)
//   reg_write_o .. jump_reg_o, illegal_o   control flags
//   branch_target_o, jump_target_o         computed targets
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ir_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  dest_o,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  output logic [31:0] imm_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_src_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        branch_ne_o,
  output logic        jump_o,
  output logic        jump_reg_o,
  output logic [31:0] branch_target_o,
  output logic [31:0] jump_target_o,
  output logic        illegal_o
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic branch_ne;
    logic jump;
    logic jump_reg;
    logic illegal;
  } ctl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
  } dat_t;

  logic [31:0]        rf [32];
  logic [4:0]         rs_p0, rt_p0;
  logic [31:0]        rs_val_p0, rt_val_p0;
  logic [31:0]        pc4_p0, sext_p0, zext_p0;
  logic signed [31:0] br_off_p0;
  logic               rw_req_p0;
  ctl_t               ctl_p0, ctl_p1;
  dat_t               dat_p0, dat_p1;
  logic               vld_p1;

  assign rs_p0     = ir_i[25:21];
  assign rt_p0     = ir_i[20:16];
  assign pc4_p0    = pc_i + 32'd4;
  assign sext_p0   = {{16{ir_i[15]}}, ir_i[15:0]};
  assign zext_p0   = {16'h0000, ir_i[15:0]};
  assign br_off_p0 = $signed({{14{ir_i[15]}}, ir_i[15:0], 2'b00});

  // ---- register file write port (independent of stall/flush) ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != 5'd0)) begin
      rf[wb_addr_i] <= wb_data_i;
    end
  end

  // ---- stage p0: operand read ----
  always_comb begin
    rs_val_p0 = (rs_p0 == 5'd0) ? 32'd0 : rf[rs_p0];
    rt_val_p0 = (rt_p0 == 5'd0) ? 32'd0 : rf[rt_p0];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs_p0)) rs_val_p0 = wb_data_i;
    if (wb_en_i && (wb_addr_i != 5'd0) && (wb_addr_i == rt_p0)) rt_val_p0 = wb_data_i;
`endif
  end

  // ---- stage p0: instruction decode ----
  always_comb begin
    ctl_p0         = '0;
    rw_req_p0      = 1'b0;
    dat_p0.pc      = pc_i;
    dat_p0.rs      = rs_p0;
    dat_p0.rt      = rt_p0;
    dat_p0.dest    = 5'd0;
    dat_p0.rs_data = rs_val_p0;
    dat_p0.rt_data = rt_val_p0;
    dat_p0.imm     = '0;
    dat_p0.alu_op  = ALU_ADD;
    dat_p0.alu_src = 1'b0;
    dat_p0.br_tgt  = pc4_p0 + $unsigned(br_off_p0);
    dat_p0.j_tgt   = {pc4_p0[31:28], ir_i[25:0], 2'b00};

    case (ir_i[31:26])
      6'h00: begin
        dat_p0.dest = ir_i[15:11];
        rw_req_p0   = 1'b1;
        case (ir_i[5:0])
          6'h00: begin dat_p0.alu_op = ALU_SLL; dat_p0.imm = {27'd0, ir_i[10:6]}; end
          6'h02: begin dat_p0.alu_op = ALU_SRL; dat_p0.imm = {27'd0, ir_i[10:6]}; end
          6'h03: begin dat_p0.alu_op = ALU_SRA; dat_p0.imm = {27'd0, ir_i[10:6]}; end
          6'h08: begin ctl_p0.jump_reg = 1'b1; rw_req_p0 = 1'b0; end
          6'h20, 6'h21: dat_p0.alu_op = ALU_ADD;
          6'h22, 6'h23: dat_p0.alu_op = ALU_SUB;
          6'h24: dat_p0.alu_op = ALU_AND;
          6'h25: dat_p0.alu_op = ALU_OR;
          6'h26: dat_p0.alu_op = ALU_XOR;
          6'h27: dat_p0.alu_op = ALU_NOR;
          6'h2A: dat_p0.alu_op = ALU_SLT;
          6'h2B: dat_p0.alu_op = ALU_SLTU;
          default: begin
            ctl_p0.illegal = 1'b1;
            rw_req_p0      = 1'b0;
            dat_p0.dest    = 5'd0;
          end
        endcase
      end
      6'h02: ctl_p0.jump = 1'b1;
      6'h03: begin
        // jal: the link value rides on imm_o and the ALU passes it through.
        ctl_p0.jump    = 1'b1;
        rw_req_p0      = 1'b1;
        dat_p0.dest    = 5'd31;
        dat_p0.imm     = pc4_p0;
        dat_p0.alu_op  = ALU_PASS;
        dat_p0.alu_src = 1'b1;
      end
      6'h04, 6'h05: begin
        ctl_p0.branch    = 1'b1;
        ctl_p0.branch_ne = ir_i[26];
        dat_p0.dest      = rt_p0;
        dat_p0.imm       = sext_p0;
        dat_p0.alu_op    = ALU_SUB;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        dat_p0.dest    = rt_p0;
        dat_p0.imm     = sext_p0;
        dat_p0.alu_src = 1'b1;
        case (ir_i[31:26])
          6'h0A:   dat_p0.alu_op = ALU_SLT;
          6'h0B:   dat_p0.alu_op = ALU_SLTU;
          default: dat_p0.alu_op = ALU_ADD;
        endcase
        ctl_p0.mem_read  = (ir_i[31:26] == 6'h23);
        ctl_p0.mem_write = (ir_i[31:26] == 6'h2B);
        rw_req_p0        = (ir_i[31:26] != 6'h2B);
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dat_p0.dest    = rt_p0;
        dat_p0.imm     = zext_p0;
        dat_p0.alu_src = 1'b1;
        rw_req_p0      = 1'b1;
        case (ir_i[27:26])
          2'b00:   dat_p0.alu_op = ALU_AND;
          2'b01:   dat_p0.alu_op = ALU_OR;
          default: dat_p0.alu_op = ALU_XOR;
        endcase
      end
      6'h0F: begin
        dat_p0.dest    = rt_p0;
        dat_p0.imm     = {ir_i[15:0], 16'h0000};
        dat_p0.alu_op  = ALU_PASS;
        dat_p0.alu_src = 1'b1;
        rw_req_p0      = 1'b1;
      end
      default: ctl_p0.illegal = 1'b1;
    endcase

    // Writes to r0 are architecturally void; this also turns 32'h0 into a nop.
    ctl_p0.reg_write = rw_req_p0 && (dat_p0.dest != 5'd0);
  end

  // ---- stage p1: IF/ID output register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1    <= 1'b0;
      ctl_p1    <= '0;
      dat_p1    <= '0;
      dat_p1.pc <= RESET_PC;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
      ctl_p1 <= '0;
    end else if (!stall_i) begin
      vld_p1 <= 1'b1;
      ctl_p1 <= ctl_p0;
      dat_p1 <= dat_p0;
    end
  end

  assign valid_o         = vld_p1;
  assign pc_o            = dat_p1.pc;
  assign rs_o            = dat_p1.rs;
  assign rt_o            = dat_p1.rt;
  assign dest_o          = dat_p1.dest;
  assign rs_data_o       = dat_p1.rs_data;
  assign rt_data_o       = dat_p1.rt_data;
  assign imm_o           = dat_p1.imm;
  assign alu_op_o        = dat_p1.alu_op;
  assign alu_src_o       = dat_p1.alu_src;
  assign branch_target_o = dat_p1.br_tgt;
  assign jump_target_o   = dat_p1.j_tgt;
  assign reg_write_o     = ctl_p1.reg_write;
  assign mem_read_o      = ctl_p1.mem_read;
  assign mem_write_o     = ctl_p1.mem_write;
  assign branch_o        = ctl_p1.branch;
  assign branch_ne_o     = ctl_p1.branch_ne;
  assign jump_o          = ctl_p1.jump;
  assign jump_reg_o      = ctl_p1.jump_reg;
  assign illegal_o       = ctl_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [31:0] pc = '0, ir = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0;

  logic        valid_o, alu_src_o, reg_write_o, mem_read_o, mem_write_o;
  logic        branch_o, branch_ne_o, jump_o, jump_reg_o, illegal_o;
  logic [31:0] pc_o, rs_data_o, rt_data_o, imm_o, branch_target_o, jump_target_o;
  logic [4:0]  rs_o, rt_o, dest_o;
  logic [3:0]  alu_op_o;

  int total = 0;
  int bad = 0;

  decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .ir_i(ir), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .valid_o(valid_o), .pc_o(pc_o), .rs_o(rs_o), .rt_o(rt_o), .dest_o(dest_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
    .branch_ne_o(branch_ne_o), .jump_o(jump_o), .jump_reg_o(jump_reg_o),
    .branch_target_o(branch_target_o), .jump_target_o(jump_target_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {
    M_SLL, M_SRL, M_SRA, M_JR, M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR,
    M_XOR, M_NOR, M_SLT, M_SLTU, M_J, M_JAL, M_BEQ, M_BNE, M_ADDI, M_ADDIU,
    M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_ILL
  } mn_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rsd, rtd, imm, bt, jt;
    logic [3:0]  op;
    logic        src, rw, mr, mw, br, bne, j, jr, ill;
  } exp_t;

  function automatic mn_t classify(input logic [31:0] i);
    mn_t m;
    m = M_ILL;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h00: m = M_SLL;  6'h02: m = M_SRL;  6'h03: m = M_SRA;  6'h08: m = M_JR;
        6'h20: m = M_ADD;  6'h21: m = M_ADDU; 6'h22: m = M_SUB;  6'h23: m = M_SUBU;
        6'h24: m = M_AND;  6'h25: m = M_OR;   6'h26: m = M_XOR;  6'h27: m = M_NOR;
        6'h2A: m = M_SLT;  6'h2B: m = M_SLTU; default: m = M_ILL;
      endcase
      6'h02: m = M_J;    6'h03: m = M_JAL;   6'h04: m = M_BEQ;  6'h05: m = M_BNE;
      6'h08: m = M_ADDI; 6'h09: m = M_ADDIU; 6'h0A: m = M_SLTI; 6'h0B: m = M_SLTIU;
      6'h0C: m = M_ANDI; 6'h0D: m = M_ORI;   6'h0E: m = M_XORI; 6'h0F: m = M_LUI;
      6'h23: m = M_LW;   6'h2B: m = M_SW;
      default: m = M_ILL;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] alu_of(input mn_t m);
    case (m)
      M_SUB, M_SUBU, M_BEQ, M_BNE: return 4'd1;
      M_AND, M_ANDI:               return 4'd2;
      M_OR, M_ORI:                 return 4'd3;
      M_XOR, M_XORI:               return 4'd4;
      M_NOR:                       return 4'd5;
      M_SLT, M_SLTI:               return 4'd6;
      M_SLTU, M_SLTIU:             return 4'd7;
      M_SLL:                       return 4'd8;
      M_SRL:                       return 4'd9;
      M_SRA:                       return 4'd10;
      M_JAL, M_LUI:                return 4'd11;
      default:                     return 4'd0;
    endcase
  endfunction

  function automatic exp_t model_decode(input logic [31:0] p, input logic [31:0] i,
                                        input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    mn_t m;
    int off;
    logic [31:0] nxt, sx;
    logic wr;
    m   = classify(i);
    r   = '0;
    nxt = p + 32'd4;
    off = int'($signed(i[15:0])) * 4;
    sx  = 32'($signed(i[15:0]));
    wr  = 1'b0;
    r.vld = 1'b1; r.pc = p; r.rs = i[25:21]; r.rt = i[20:16]; r.rsd = a; r.rtd = b;
    r.bt = nxt + 32'(off);
    r.jt = {nxt[31:28], i[25:0], 2'b00};
    r.op = alu_of(m);
    case (m)
      M_SLL, M_SRL, M_SRA: begin r.dest = i[15:11]; r.imm = {27'd0, i[10:6]}; wr = 1'b1; end
      M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU:
        begin r.dest = i[15:11]; wr = 1'b1; end
      M_JR:  begin r.dest = i[15:11]; r.jr = 1'b1; end
      M_J:   r.j = 1'b1;
      M_JAL: begin r.j = 1'b1; r.dest = 5'd31; r.imm = nxt; r.src = 1'b1; wr = 1'b1; end
      M_BEQ, M_BNE: begin r.br = 1'b1; r.bne = (m == M_BNE); r.dest = i[20:16]; r.imm = sx; end
      M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_LW:
        begin r.dest = i[20:16]; r.imm = sx; r.src = 1'b1; wr = 1'b1; r.mr = (m == M_LW); end
      M_SW:  begin r.dest = i[20:16]; r.imm = sx; r.src = 1'b1; r.mw = 1'b1; end
      M_ANDI, M_ORI, M_XORI:
        begin r.dest = i[20:16]; r.imm = {16'h0, i[15:0]}; r.src = 1'b1; wr = 1'b1; end
      M_LUI: begin r.dest = i[20:16]; r.imm = {i[15:0], 16'h0}; r.src = 1'b1; wr = 1'b1; end
      default: r.ill = 1'b1;
    endcase
    r.rw = wr && (r.dest != 5'd0);
    return r;
  endfunction

  function automatic exp_t reset_exp();
    exp_t r;
    r = '0;
    r.pc = RST_PC;
    return r;
  endfunction

  logic [31:0] rf_m [32];
  exp_t        e, t;
  logic        known;
  logic [31:0] rsv, rtv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e     <= reset_exp();
      known <= 1'b1;
      for (int k = 0; k < 32; k++) rf_m[k] <= '0;
    end else begin
      rsv = (ir[25:21] == 5'd0) ? 32'd0 : rf_m[ir[25:21]];
      rtv = (ir[20:16] == 5'd0) ? 32'd0 : rf_m[ir[20:16]];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && wb_addr != 5'd0 && wb_addr == ir[25:21]) rsv = wb_data;
      if (wb_en && wb_addr != 5'd0 && wb_addr == ir[20:16]) rtv = wb_data;
`endif
      t = e;
      if (flush) begin
        t.vld = 0; t.rw = 0; t.mr = 0; t.mw = 0; t.br = 0; t.bne = 0;
        t.j = 0; t.jr = 0; t.ill = 0;
        known <= 1'b0;
      end else if (!stall) begin
        t = model_decode(pc, ir, rsv, rtv);
        known <= 1'b1;
      end
      e <= t;
      if (wb_en && wb_addr != 5'd0) rf_m[wb_addr] <= wb_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  exp_t x;
  always @(negedge clk) begin
    x = rst_n ? e : reset_exp();
    chk("valid", 32'(valid_o), 32'(x.vld));
    chk("reg_write", 32'(reg_write_o), 32'(x.rw));
    chk("mem_read", 32'(mem_read_o), 32'(x.mr));
    chk("mem_write", 32'(mem_write_o), 32'(x.mw));
    chk("branch", 32'(branch_o), 32'(x.br));
    chk("branch_ne", 32'(branch_ne_o), 32'(x.bne));
    chk("jump", 32'(jump_o), 32'(x.j));
    chk("jump_reg", 32'(jump_reg_o), 32'(x.jr));
    chk("illegal", 32'(illegal_o), 32'(x.ill));
    if (!rst_n || known) begin
      chk("pc", pc_o, x.pc);
      chk("rs", 32'(rs_o), 32'(x.rs));
      chk("rt", 32'(rt_o), 32'(x.rt));
      chk("dest", 32'(dest_o), 32'(x.dest));
      chk("rs_data", rs_data_o, x.rsd);
      chk("rt_data", rt_data_o, x.rtd);
      chk("imm", imm_o, x.imm);
      chk("alu_op", 32'(alu_op_o), 32'(x.op));
      chk("alu_src", 32'(alu_src_o), 32'(x.src));
      chk("br_target", branch_target_o, x.bt);
      chk("j_target", jump_target_o, x.jt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [31:0] p, input logic [31:0] i, input logic st,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    pc = p; ir = i; stall = st; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_pc [12];
  logic [31:0] vec_ir [12];
  logic [31:0] byp_exp;

  initial begin
    vec_pc = '{32'h0000_0500, 32'h0000_0504, 32'h0000_0508, 32'h0000_050C,
               32'h0000_0510, 32'h0000_0514, 32'h0000_0518, 32'h0000_051C,
               32'h0000_0520, 32'h0000_0524, 32'h0000_0528, 32'h0000_0008};
    vec_ir = '{32'h0009_1100, 32'h3104_8001, 32'hAD09_FFF8, 32'h1509_0003,
               32'h0009_2FC3, 32'h0100_0008, 32'h0800_0400, 32'h2806_FFFF,
               32'h3907_FF00, 32'h8D0B_0004, 32'h0109_6027, 32'h1000_FFFC};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_pc", pc_o, RST_PC);
    rst_n = 1'b1;

    // first live edge: nop capture while writing r8, then r9
    step(32'h0, 32'h0, 0, 0, 1, 5'd8, 32'h1234_5678);
    chk("first_valid", 32'(valid_o), 32'd1);
    chk("nop_rw", 32'(reg_write_o), 32'd0);
    step(32'h0, 32'h0, 0, 0, 1, 5'd9, 32'h0000_0011);

    // add r10,r8,r9
    step(32'h0000_0040, 32'h0109_5020, 0, 0, 0, 5'd0, 32'h0);
    chk("add_rsd", rs_data_o, 32'h1234_5678);
    chk("add_rtd", rt_data_o, 32'h0000_0011);
    chk("add_op", 32'(alu_op_o), 32'd0);
    chk("add_dest", 32'(dest_o), 32'd10);
    chk("add_rw", 32'(reg_write_o), 32'd1);

    // beq r8,r8,-1
    step(32'h0000_0100, 32'h1108_FFFF, 0, 0, 0, 5'd0, 32'h0);
    chk("beq_br", 32'(branch_o), 32'd1);
    chk("beq_tgt", branch_target_o, 32'h0000_0100);

    // lui r1 / jal
    step(32'h0000_0104, 32'h3C01_ABCD, 0, 0, 0, 5'd0, 32'h0);
    chk("lui_imm", imm_o, 32'hABCD_0000);
    chk("lui_src", 32'(alu_src_o), 32'd1);
    step(32'h0000_0200, 32'h0C00_0040, 0, 0, 0, 5'd0, 32'h0);
    chk("jal_dest", 32'(dest_o), 32'd31);
    chk("jal_imm", imm_o, 32'h0000_0204);
    chk("jal_jt", jump_target_o, 32'h0000_0100);

    // stall twice with a different instruction offered, then flush with stall
    step(32'h0000_0300, 32'h0109_5020, 1, 0, 0, 5'd0, 32'h0);
    step(32'h0000_0304, 32'h0109_5020, 1, 0, 0, 5'd0, 32'h0);
    chk("stall_dest", 32'(dest_o), 32'd31);
    chk("stall_imm", imm_o, 32'h0000_0204);
    chk("stall_pc", pc_o, 32'h0000_0200);
    step(32'h0000_0308, 32'h0109_5020, 1, 1, 0, 5'd0, 32'h0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_jump", 32'(jump_o), 32'd0);
    step(32'h0000_0400, 32'hFC00_0000, 0, 0, 0, 5'd0, 32'h0);
    chk("ill", 32'(illegal_o), 32'd1);
    chk("ill_rw", 32'(reg_write_o), 32'd0);

    // assorted instructions checked by the model; pin a few by hand
    for (int v = 0; v < 12; v++) begin
      step(vec_pc[v], vec_ir[v], 0, 0, 0, 5'd0, 32'h0);
      if (v == 1) chk("andi_zext", imm_o, 32'h0000_8001);
      if (v == 3) chk("bne_ne", 32'(branch_ne_o), 32'd1);
      if (v == 11) chk("beq_wrap", branch_target_o, 32'hFFFF_FFFC);
    end
    step(32'hFFFF_FFFC, 32'h0800_0400, 0, 0, 0, 5'd0, 32'h0);
    chk("j_wrap", jump_target_o, 32'h0000_1000);

    // same-cycle write/read of r3
    step(32'h0000_0600, 32'h0, 0, 0, 1, 5'd3, 32'd5);
    step(32'h0000_0604, 32'h0060_2020, 0, 0, 1, 5'd3, 32'd7);
`ifdef DECODE_WB_BYPASS_EN
    byp_exp = 32'd7;
`else
    byp_exp = 32'd5;
`endif
    chk("same_cycle_r3", rs_data_o, byp_exp);
    step(32'h0000_0608, 32'h0060_2020, 0, 0, 0, 5'd0, 32'h0);
    chk("r3_after", rs_data_o, 32'd7);
    step(32'h0000_060C, 32'h0000_0020, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);
    chk("r0_same", rs_data_o, 32'd0);
    chk("r0_rw", 32'(reg_write_o), 32'd0);
    step(32'h0000_0610, 32'h0000_0020, 0, 0, 0, 5'd0, 32'h0);
    chk("r0_after", rt_data_o, 32'd0);

    // write r5, read it, then reset mid-cycle
    step(32'h0000_0700, 32'h0, 0, 0, 1, 5'd5, 32'h0000_0055);
    step(32'h0000_0704, 32'h00A0_0020, 0, 0, 0, 5'd0, 32'h0);
    chk("r5_read", rs_data_o, 32'h0000_0055);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(valid_o), 32'd0);
    chk("async_pc", pc_o, RST_PC);
    chk("async_rsd", rs_data_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(32'h0000_0800, 32'h00A0_0020, 0, 0, 0, 5'd0, 32'h0);
    chk("r5_cleared", rs_data_o, 32'd0);
    chk("post_rst_valid", 32'(valid_o), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
